// File: rtl/prog_loader.sv
// Program download loader: receives a byte-stream program, writes it into
// instruction memory, starts the processor and times the run until Halt.
// Optional download checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Load,
  input  logic              InValid,
  input  logic [7:0]        InByte,
  output logic              InReady,
  output logic              IWrite,
  output logic [ADDR_W-1:0] IAddr,
  output logic [8:0]        IData,
  output logic              start,
  input  logic              Halt,
  output logic              Done,
  output logic              Error,
  output logic [CNT_W-1:0]  CycleCount
);

  // Index/count width must hold 2^ADDR_W and any header byte value.
  localparam int unsigned IDX_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_LO, S_HI, S_WRITE, S_CSUM, S_STRT, S_RUN, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_LO, S_HI, S_WRITE, S_STRT, S_RUN, S_DONE, S_ERR
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   idx_inc;
  logic [8:0]         data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               iwrite_q, iwrite_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  assign xfer    = InValid && in_ready_q;
  assign idx_inc = idx_q + IDX_W'(1);

  // Next-state and datapath; registered outputs decode the next state.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Load) state_d = S_HDR;
      end
      S_HDR: begin
        if (xfer) begin
          n_d     = (InByte == 8'd0) ? IDX_W'(DEPTH) : IDX_W'(InByte);
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = InByte;
`endif
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          data_d[7:0] = InByte;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = csum_q + InByte;
`endif
          state_d     = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          if (InByte[7:1] != 7'd0) begin
            state_d = S_ERR;
          end else begin
            data_d[8] = InByte[0];
`ifdef LOADER_CHECKSUM_EN
            csum_d    = csum_q + InByte;
`endif
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc < n_q) begin
          state_d = S_LO;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_STRT;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (InByte == csum_q) ? S_STRT : S_ERR;
      end
`endif
      S_STRT: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (Halt) begin
          state_d = S_DONE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE, S_ERR: begin
        if (Load) begin
          cnt_d   = '0;
          state_d = S_HDR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_HDR) || (state_d == S_LO) || (state_d == S_HI)
`ifdef LOADER_CHECKSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
    iwrite_d = (state_d == S_WRITE);
    start_d  = (state_d == S_STRT);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_ERR);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      iwrite_q   <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      iwrite_q   <= iwrite_d;
      start_q    <= start_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign InReady    = in_ready_q;
  assign IWrite     = iwrite_q;
  assign IAddr      = idx_q[ADDR_W-1:0];
  assign IData      = data_q;
  assign start      = start_q;
  assign Done       = done_q;
  assign Error      = error_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a download-stream model predicts the
// memory writes, start and error outcome; directed tests pin run timing.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 6;
  localparam int WR_W   = ADDR_W + 9;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              Load = 1'b0;
  logic              InValid = 1'b0;
  logic [7:0]        InByte = 8'h00;
  logic              InReady;
  logic              IWrite;
  logic [ADDR_W-1:0] IAddr;
  logic [8:0]        IData;
  logic              start;
  logic              Halt = 1'b0;
  logic              Done;
  logic              Error;
  logic [CNT_W-1:0]  CycleCount;

  prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .Load(Load), .InValid(InValid), .InByte(InByte),
    .InReady(InReady), .IWrite(IWrite), .IAddr(IAddr), .IData(IData),
    .start(start), .Halt(Halt), .Done(Done), .Error(Error),
    .CycleCount(CycleCount)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  logic prev_start = 1'b0;

  logic [7:0]      prog[$];
  logic [WR_W-1:0] exp_wr[$];
  bit exp_err, exp_start;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Download model: header count, LO/HI pairs, optional checksum byte.
  task automatic model_program();
    int n, i;
    logic [7:0] sum;
    exp_wr.delete();
    exp_err = 1'b0;
    exp_start = 1'b0;
    n = (prog[0] == 8'h00) ? (1 << ADDR_W) : int'(prog[0]);
    sum = prog[0];
    i = 1;
    for (int k = 0; k < n; k++) begin
      if (i + 1 >= prog.size()) return;
      if (prog[i+1][7:1] != 7'd0) begin
        exp_err = 1'b1;
        return;
      end
      exp_wr.push_back({ADDR_W'(k), prog[i+1][0], prog[i]});
      sum = sum + prog[i] + prog[i+1];
      i += 2;
    end
`ifdef LOADER_CHECKSUM_EN
    if (i >= prog.size()) return;
    if (prog[i] == sum) exp_start = 1'b1;
    else exp_err = 1'b1;
`else
    exp_start = 1'b1;
`endif
  endtask

  task automatic append_csum(input int delta);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'(delta);
    foreach (prog[j]) s = s + prog[j];
    prog.push_back(s);
`else
    if (delta != 0) $display("note: checksum delta unused");
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit sent;
    int t;
    sent = 1'b0;
    t = 0;
    while (!sent) begin
      @(negedge CLK);
      InValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      InByte  = InValid ? b : 8'($urandom);
      if (InValid && InReady) sent = 1'b1;
      t++;
      if (!sent && t > 300) begin
        check("send_timeout", 32'(t), 32'd0);
        sent = 1'b1;
      end
    end
  endtask

  task automatic send_prog(input bit gaps);
    foreach (prog[j]) send_byte(prog[j], gaps);
    @(negedge CLK);
    InValid = 1'b0;
  endtask

  task automatic load_pulse();
    @(negedge CLK);
    Load = 1'b1;
    @(negedge CLK);
    Load = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    for (int t = 0; t < 40; t++) begin
      if (start || Error) break;
      @(negedge CLK);
    end
    check({nm, "_start"}, 32'(start), 32'(exp_start));
    check({nm, "_error"}, 32'(Error), 32'(exp_err));
    check({nm, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
  endtask

  // Called at the negedge of the start cycle: n Halt=0 RUN cycles, then Halt.
  task automatic run_halt(input int n, input int exp_cnt, input string nm);
    Halt = 1'b0;
    @(posedge CLK);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
    Halt = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Halt = 1'b0;
    check({nm, "_done"}, 32'(Done), 32'd1);
    check({nm, "_count"}, 32'(CycleCount), 32'(exp_cnt));
    check({nm, "_inready"}, 32'(InReady), 32'd0);
  endtask

  task automatic check_reset(input string nm);
    check(nm, 32'({InReady, IWrite, start, Done, Error, IAddr, IData, CycleCount}), 32'd0);
  endtask

  // Per-cycle compare of write strobes and start pulses against the model.
  always @(negedge CLK) begin
    if (!Reset) begin
      if (IWrite) begin
        check("wr_inready_low", 32'(InReady), 32'd0);
        check("wr_start_excl", 32'(start), 32'd0);
        if (exp_wr.size() == 0) check("wr_unexpected", 32'(IAddr), 32'hFFFF_FFFF);
        else check("wr_addr_data", 32'({IAddr, IData}), 32'(exp_wr.pop_front()));
        wr_cnt++;
      end
      if (start) begin
        start_cnt++;
        check("start_width", 32'(prev_start), 32'd0);
      end
    end
    prev_start = start;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, s0;
    repeat (3) @(negedge CLK);
    check_reset("reset_init");
    Reset = 1'b0;
    @(negedge CLK);
    check("idle_inready", 32'(InReady), 32'd0);

    // Two-word program, then a 37-cycle run.
    load_pulse();
    check("hdr_inready", 32'(InReady), 32'd1);
    prog = '{8'h02, 8'h15, 8'h01, 8'hA0, 8'h00};
    append_csum(0);
    model_program();
    check("model_wr0", 32'(exp_wr[0]), 32'h0000_0115);
    check("model_wr1", 32'(exp_wr[1]), 32'h0000_02A0);
    w0 = wr_cnt;
    send_prog(1'b0);
    wait_end("basic");
    check("basic_nwr", 32'(wr_cnt - w0), 32'd2);
    run_halt(37, 37, "run37");
    repeat (5) @(negedge CLK);
    check("done_hold", 32'({Done, Error, CycleCount}), 32'({1'b1, 1'b0, 6'd37}));

    // Reload from DONE clears results; Load held high mid-download is ignored.
    @(negedge CLK);
    Load = 1'b1;
    @(negedge CLK);
    check("reload_clear", 32'({Done, CycleCount, InReady}), 32'h1);
    prog = '{8'h03, 8'h7F, 8'h00, 8'h80, 8'h01, 8'hFF, 8'h01};
    append_csum(0);
    model_program();
    w0 = wr_cnt;
    send_prog(1'b1);
    Load = 1'b0;
    wait_end("gaps");
    check("gaps_nwr", 32'(wr_cnt - w0), 32'd3);
    run_halt(0, 0, "halt_first");

    // Malformed HI byte.
    load_pulse();
    prog = '{8'h01, 8'h33, 8'h02};
    model_program();
    w0 = wr_cnt;
    s0 = start_cnt;
    send_prog(1'b0);
    wait_end("bad_hi");
    repeat (5) @(negedge CLK);
    check("bad_hi_nwr", 32'(wr_cnt - w0), 32'd0);
    check("bad_hi_nostart", 32'(start_cnt - s0), 32'd0);
    check("err_hold", 32'({Error, Done, InReady}), 32'h4);

    // Reset mid-download, then a fresh program from address 0.
    load_pulse();
    check("err_reload", 32'({Error, InReady}), 32'h1);
    prog = '{8'h02, 8'h15, 8'h01};
    model_program();
    send_prog(1'b0);
    repeat (3) @(negedge CLK);
    check("partial_wr_done", 32'(exp_wr.size()), 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset("reset_mid");
    Reset = 1'b0;
    load_pulse();
    prog = '{8'h02, 8'h15, 8'h01, 8'hA0, 8'h00};
    append_csum(0);
    model_program();
    send_prog(1'b0);
    wait_end("after_reset");
    run_halt(70, 63, "saturate");

    // Halt held high outside RUN must not end the download early.
    Halt = 1'b1;
    load_pulse();
    prog = '{8'h01, 8'h55, 8'h00};
    append_csum(0);
    model_program();
    send_prog(1'b0);
    wait_end("halt_hi");
    repeat (2) @(negedge CLK);
    check("halt_hi_result", 32'({Done, CycleCount}), 32'({1'b1, 6'd0}));
    Halt = 1'b0;

    // Header 0 means a full 2^ADDR_W-word program.
    load_pulse();
    prog = '{8'h00};
    for (int k = 0; k < (1 << ADDR_W); k++) begin
      prog.push_back(8'($urandom));
      prog.push_back(8'($urandom_range(0, 1)));
    end
    append_csum(0);
    model_program();
    check("model_full_len", 32'(exp_wr.size()), 32'd256);
    w0 = wr_cnt;
    send_prog(1'b0);
    wait_end("full");
    check("full_nwr", 32'(wr_cnt - w0), 32'd256);
    run_halt(5, 5, "full_run");

`ifdef LOADER_CHECKSUM_EN
    load_pulse();
    prog = '{8'h01, 8'h10, 8'h01, 8'h12};
    model_program();
    check("model_csum_ok", 32'(exp_start), 32'd1);
    send_prog(1'b0);
    wait_end("csum_ok");
    run_halt(2, 2, "csum_run");
    load_pulse();
    prog = '{8'h01, 8'h10, 8'h01, 8'h13};
    model_program();
    check("model_csum_bad", 32'(exp_err), 32'd1);
    s0 = start_cnt;
    send_prog(1'b0);
    wait_end("csum_bad");
    repeat (3) @(negedge CLK);
    check("csum_bad_nostart", 32'(start_cnt - s0), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
